ntt_out_drain: RTL and testbench



---
 rtl/ntt_drain_pkg.sv | 30 +++
 rtl/drain_fifo.sv | 66 ++++++
 rtl/ntt_out_drain.sv | 160 ++++++++++++++++
 tb/tb_ntt_out_drain.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_drain_pkg.sv
// Shared types and helpers for the NTT output drain sequencer.
package ntt_drain_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } drain_state_e;

    localparam int BANK_NUM     = 16;
    localparam int BITREV_MAX_W = 8;

    // Reverses the low 'width' bits of idx; bits above 'width' come back zero.
    function automatic logic [BITREV_MAX_W-1:0] bit_rev(
        input logic [BITREV_MAX_W-1:0] idx,
        input int unsigned             width
    );
        logic [BITREV_MAX_W-1:0] r;
        r = {BITREV_MAX_W{1'b0}};
        for (int i = 0; i < BITREV_MAX_W; i++) begin
            for (int j = 0; j < BITREV_MAX_W; j++) begin
                if (i + j == int'(width) - 1) begin
                    r[i] = idx[j];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/drain_fifo.sv
// Small shift-register FIFO: entry 0 is the registered head, so the read side
// never sees a combinational path from the write data.
module drain_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             rd_valid_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        valid_q, valid_d;
    logic                        pop_s, push_s;
    logic [IDX_W-1:0]            wr_idx_s;

    // Next-state: pop shifts toward the head, push lands behind the last live entry.
    always_comb begin
        mem_d    = mem_q;
        cnt_d    = cnt_q;
        pop_s    = rd_en_i & valid_q;
        push_s   = wr_en_i & ((cnt_q != CNT_W'(DEPTH)) | pop_s);
        wr_idx_s = IDX_W'(pop_s ? (cnt_q - CNT_W'(1)) : cnt_q);
        if (pop_s) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i + 1];
            end
            cnt_d = cnt_d - CNT_W'(1);
        end else begin
            cnt_d = cnt_d;
        end
        if (push_s) begin
            mem_d[wr_idx_s] = wr_data_i;
            cnt_d           = cnt_d + CNT_W'(1);
        end else begin
            cnt_d = cnt_d;
        end
        valid_d = (cnt_d != CNT_W'(0));
    end

    // Storage, occupancy and head-valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '0;
            cnt_q   <= CNT_W'(0);
            valid_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign rd_data_o  = mem_q[0];
    assign rd_valid_o = valid_q;
    assign count_o    = cnt_q;

endmodule

// File: rtl/ntt_out_drain.sv
// Drains all banks row by row through the 16:1 output mux into a valid/ready stream.
// Build option NTT_DRAIN_BITREV_EN: bank index within a row issued in bit-reversed order.
`ifndef D_width
`define D_width 32
`endif
`ifndef POW_RADIX_K1
`define POW_RADIX_K1 4
`endif
module ntt_out_drain
    import ntt_drain_pkg::*;
#(
    parameter int D_WIDTH = `D_width,
    parameter int SEL_W   = `POW_RADIX_K1,
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               bank_rd_en,
    output logic [ADDR_W-1:0]  bank_rd_addr,
    output logic [SEL_W-1:0]   sel_out,
    input  logic [D_WIDTH-1:0] Q_out,
    output logic [D_WIDTH-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last
);
    localparam int BANKS      = 1 << SEL_W;
    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int CNT_W      = SEL_W + ADDR_W;
    localparam int FCNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BANKS * DEPTH - 1);

    drain_state_e               state_q;
    logic [CNT_W-1:0]           beat_q;
    logic                       busy_q, done_q, rd_en_q;
    logic [ADDR_W-1:0]          addr_q;
    logic [SEL_W-1:0]           iss_bank_q;
    logic                       iss_last_q;
    logic [RD_LAT-1:0][SEL_W-1:0] sel_pipe_q;
    logic [RD_LAT-1:0]          vld_pipe_q;
    logic [RD_LAT-1:0]          last_pipe_q;

    logic [SEL_W-1:0]   nat_bank_s, bank_s;
    logic [ADDR_W-1:0]  row_s;
    logic               last_s, issue_s, credit_s, pop_s, fifo_last_s;
    int                 inflight_s;
    logic [FCNT_W-1:0]  fifo_cnt_s;
    logic [D_WIDTH-1:0] fifo_data_s;

    // Beat index to (row, bank) and issue decision under the credit rule.
    always_comb begin
        nat_bank_s = beat_q[SEL_W-1:0];
        row_s      = beat_q[CNT_W-1:SEL_W];
`ifdef NTT_DRAIN_BITREV_EN
        bank_s     = SEL_W'(bit_rev(BITREV_MAX_W'(nat_bank_s), SEL_W));
`else
        bank_s     = nat_bank_s;
`endif
        last_s     = (beat_q == LAST_BEAT);
        pop_s      = out_valid & out_ready;
        inflight_s = int'(rd_en_q);
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_s = inflight_s + int'(vld_pipe_q[i]);
        end
        // A head leaving this cycle frees its slot in time for the new read.
        credit_s = (int'(fifo_cnt_s) + inflight_s - int'(pop_s)) < FIFO_DEPTH;
        if ((state_q == IDLE && start) || state_q == RUN) begin
            issue_s = credit_s;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Sequencer FSM with issue registers and the select/valid/last pipes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= CNT_W'(0);
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= ADDR_W'(0);
            iss_bank_q  <= SEL_W'(0);
            iss_last_q  <= 1'b0;
            sel_pipe_q  <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
        end else begin
            done_q         <= 1'b0;
            rd_en_q        <= issue_s;
            vld_pipe_q[0]  <= rd_en_q;
            sel_pipe_q[0]  <= iss_bank_q;
            last_pipe_q[0] <= iss_last_q;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_q[i]  <= vld_pipe_q[i-1];
                sel_pipe_q[i]  <= sel_pipe_q[i-1];
                last_pipe_q[i] <= last_pipe_q[i-1];
            end
            if (issue_s) begin
                addr_q     <= row_s;
                iss_bank_q <= bank_s;
                iss_last_q <= last_s;
                beat_q     <= last_s ? CNT_W'(0) : beat_q + CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue_s && last_s) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (pop_s && fifo_last_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    drain_fifo #(
        .WIDTH (D_WIDTH + 1),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (FCNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (vld_pipe_q[RD_LAT-1]),
        .wr_data_i  ({last_pipe_q[RD_LAT-1], Q_out}),
        .rd_en_i    (out_ready),
        .rd_data_o  ({fifo_last_s, fifo_data_s}),
        .rd_valid_o (out_valid),
        .count_o    (fifo_cnt_s)
    );

    assign busy         = busy_q;
    assign done         = done_q;
    assign bank_rd_en   = rd_en_q;
    assign bank_rd_addr = addr_q;
    assign sel_out      = sel_pipe_q[RD_LAT-1];
    assign out_data     = fifo_data_s;
    assign out_last     = fifo_last_s;

endmodule

// File: tb/tb_ntt_out_drain.sv
// Bench for ntt_out_drain: DEPTH=4, RD_LAT=1, bank b row r returns {b, r}.
module tb_ntt_out_drain;

    typedef struct {
        int ready_mode;   // 0 always ready, 1 alternate, 3 random
        int stall_at;     // beat after which ready drops, -1 none
        int stall_len;
        int restart_at;   // beat count at which start is re-pulsed, -1 none
        int exp_beats;
        int exp_dones;
    } case_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       out_ready = 1'b0;
    logic       busy, done, bank_rd_en, out_valid, out_last;
    logic [1:0] bank_rd_addr;
    logic [3:0] sel_out;
    logic [7:0] Q_out, out_data;
    logic [1:0] row_q = 2'd0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int issued, beats_seen, done_cnt, last_hs_cyc, first_hs_cyc;
    bit mon_en = 1'b0;
    bit hold_prev = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [7:0] sb[$];
    case_t      cases[5];

    ntt_out_drain #(
        .D_WIDTH (8),
        .SEL_W   (4),
        .DEPTH   (4),
        .RD_LAT  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .bank_rd_en   (bank_rd_en),
        .bank_rd_addr (bank_rd_addr),
        .sel_out      (sel_out),
        .Q_out        (Q_out),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bank array with one-cycle read latency followed by the mux.
    always @(posedge clk) begin
        if (bank_rd_en) row_q <= bank_rd_addr;
    end
    assign Q_out = {sel_out, 2'b00, row_q};

    function automatic logic [7:0] exp_word(input int k);
        logic [3:0] b;
        logic [3:0] r;
        b = 4'(k % 16);
        r = 4'(k / 16);
`ifdef NTT_DRAIN_BITREV_EN
        b = {b[0], b[1], b[2], b[3]};
`endif
        return {b, r};
    endfunction

    task automatic chk_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic chk_le(input string name, input int act, input int lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s: got %0d expected at most %0d at cycle %0d", name, act, lim, cyc);
        end
    endtask

    task automatic reset_mon();
        issued = 0; beats_seen = 0; done_cnt = 0;
        last_hs_cyc = -100; first_hs_cyc = -100; hold_prev = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_eq({tag, "_busy"}, int'(busy), 0);
        chk_eq({tag, "_done"}, int'(done), 0);
        chk_eq({tag, "_rd_en"}, int'(bank_rd_en), 0);
        chk_eq({tag, "_addr"}, int'(bank_rd_addr), 0);
        chk_eq({tag, "_sel"}, int'(sel_out), 0);
        chk_eq({tag, "_data"}, int'(out_data), 0);
        chk_eq({tag, "_valid"}, int'(out_valid), 0);
        chk_eq({tag, "_last"}, int'(out_last), 0);
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bank_rd_en) issued++;
            chk_le("credit", issued - beats_seen, 3);
            if (hold_prev) begin
                chk_eq("hold_valid", int'(out_valid), 1);
                chk_eq("hold_data", int'(out_data), int'(prev_data));
                chk_eq("hold_last", int'(out_last), int'(prev_last));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk_eq("extra_beat", beats_seen, -1);
                end else begin
                    chk_eq("beat_data", int'(out_data), int'(sb.pop_front()));
                end
                chk_eq("beat_last", int'(out_last), int'(beats_seen == 63));
                if (beats_seen == 0) first_hs_cyc = cyc;
                if (beats_seen == 63) last_hs_cyc = cyc;
                beats_seen++;
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (done) begin
                done_cnt++;
                chk_eq("done_timing", cyc - 1, last_hs_cyc);
                chk_eq("busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic run_case(input case_t c);
        int  stall_left;
        int  post;
        bit  stall_done;
        bit  pulsed;
        bit  finished;
        stall_left = 0; post = 0; stall_done = 1'b0; pulsed = 1'b0; finished = 1'b0;
        for (int k = 0; k < 64; k++) sb.push_back(exp_word(k));
        reset_mon();
        mon_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n < 3000 && !finished; n++) begin
            if (c.stall_at >= 0 && !stall_done && beats_seen == c.stall_at + 1) begin
                stall_left = c.stall_len;
                stall_done = 1'b1;
            end
            case (c.ready_mode)
                1: out_ready = n[0];
                3: out_ready = 1'($urandom_range(1, 0));
                default: out_ready = 1'b1;
            endcase
            if (stall_left > 0) begin
                out_ready = 1'b0;
                if (stall_left == 1) begin
                    chk_eq("stall_rd_en", int'(bank_rd_en), 0);
                    chk_eq("stall_valid", int'(out_valid), 1);
                    chk_eq("stall_data", int'(out_data), int'(exp_word(c.stall_at + 1)));
                end
                stall_left--;
            end
            start = (c.restart_at >= 0 && !pulsed && beats_seen == c.restart_at);
            if (start) pulsed = 1'b1;
            if (n == 1) begin
                chk_eq("t1_rd_en", int'(bank_rd_en), 1);
                chk_eq("t1_busy", int'(busy), 1);
                chk_eq("t1_addr", int'(bank_rd_addr), 0);
            end
            if (n == 2) begin
                chk_eq("t2_valid", int'(out_valid), 0);
                chk_eq("t2_sel", int'(sel_out), 0);
            end
            if (n == 3) begin
                chk_eq("t3_valid", int'(out_valid), 1);
                chk_eq("t3_data", int'(out_data), int'(exp_word(0)));
            end
            if (done_cnt > 0) post++;
            if (post > 5) finished = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        mon_en = 1'b0;
        chk_eq("completed", int'(finished), 1);
        chk_eq("beat_count", beats_seen, c.exp_beats);
        chk_eq("done_count", done_cnt, c.exp_dones);
        chk_eq("sb_empty", sb.size(), 0);
        chk_eq("idle_busy", int'(busy), 0);
        if (c.ready_mode == 0 && c.stall_at < 0) begin
            chk_eq("throughput", last_hs_cyc - first_hs_cyc, 63);
        end
        sb.delete();
    endtask

    initial begin
        cases[0] = '{0, -1, 0, -1, 64, 1};
        cases[1] = '{1, -1, 0, -1, 64, 1};
        cases[2] = '{0, 5, 20, -1, 64, 1};
        cases[3] = '{0, -1, 0, 10, 64, 1};
        cases[4] = '{3, -1, 0, -1, 64, 1};

        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run_case(cases[i]);
            repeat (2) @(posedge clk);
            #1;
        end

        // Reset in the middle of a drain, then a fresh drain from beat 0.
        for (int k = 0; k < 64; k++) sb.push_back(exp_word(k));
        reset_mon();
        mon_en = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 500 && beats_seen < 30; n++) begin
            @(posedge clk); #1;
        end
        chk_eq("reach_beat30", beats_seen, 30);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_all_zero("midrst");
        mon_en = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        run_case(cases[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
